// File: rtl/syn_fifo_gen_pkg.sv
// Shared constants for the parametrised FIFO: level width helper and
// output-mode encodings.
package syn_fifo_gen_pkg;

  localparam int FWFT_ON  = 1;
  localparam int FWFT_OFF = 0;

  // Occupancy needs one bit more than a pointer to represent a full FIFO.
  function automatic int lvl_w(input int addr_width);
    return addr_width + 1;
  endfunction

  localparam int LVL_W_DEF = lvl_w(6);

endpackage

// File: rtl/syn_fifo_gen_regf.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module fifo_regf_2p #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 42
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/syn_fifo_gen.sv
// Single-clock FIFO with arbitrary depth, programmable thresholds, sticky
// error flags and selectable first-word-fall-through or registered output.
module syn_fifo_gen
  import syn_fifo_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 42,
  parameter int AFULL_THR  = DEPTH - 2,
  parameter int AEMPTY_THR = 2,
  parameter int FWFT       = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [lvl_w(ADDR_WIDTH)-1:0]  level,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clr_err
);

  localparam int LW = lvl_w(ADDR_WIDTH);
  localparam logic [LW-1:0]         LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]         LVL_AF   = LW'(AFULL_THR);
  localparam logic [LW-1:0]         LVL_AE   = LW'(AEMPTY_THR);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  // Flags come straight from the registered level so they never glitch.
  assign empty        = (level_q == '0);
  assign full         = (level_q == LVL_FULL);
  assign almost_empty = (level_q <= LVL_AE);
  assign almost_full  = (level_q >= LVL_AF);
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A read frees a slot in the same cycle, so a write into a full FIFO
  // is still accepted when paired with a read.
  assign rd_acc = rd_en & ~empty & ~flush;
  assign wr_acc = wr_en & (~full | rd_acc) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // A same-cycle rejection beats clr_err; flush neither sets nor clears.
  always_comb begin
    ovf_d = (clr_err ? 1'b0 : ovf_q) | (~flush & wr_en & ~wr_acc);
    unf_d = (clr_err ? 1'b0 : unf_q) | (~flush & rd_en & empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_regf_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regf (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      assign data_out = empty ? '0 : rd_data;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         dout_q <= '0;
        else if (flush)  dout_q <= '0;
        else if (rd_acc) dout_q <= rd_data;
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_syn_fifo_gen.sv
// Scoreboard bench: default FWFT FIFO (42 deep) plus a registered-output
// instance (5 deep).
module tb_syn_fifo_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       flush = 0, wr_en = 0, rd_en = 0, clr_err = 0;
  logic [7:0] data_in = 0, data_out;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [6:0] level;

  logic       r_flush = 0, r_wr_en = 0, r_rd_en = 0, r_clr_err = 0;
  logic [7:0] r_data_in = 0, r_data_out;
  logic       r_empty, r_full, r_ae, r_af, r_ovf, r_unf;
  logic [3:0] r_level;

  syn_fifo_gen dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  syn_fifo_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .DEPTH(5), .FWFT(0)) dut_r (
    .clk(clk), .rst(rst), .flush(r_flush), .wr_en(r_wr_en), .data_in(r_data_in),
    .rd_en(r_rd_en), .data_out(r_data_out), .empty(r_empty), .full(r_full),
    .almost_empty(r_ae), .almost_full(r_af), .level(r_level),
    .overflow(r_ovf), .underflow(r_unf), .clr_err(r_clr_err)
  );

  int checks = 0, errs = 0;

  logic [7:0] q[$];
  int         mlvl = 0;
  bit         movf = 0, munf = 0;

  logic [7:0] rq[$];
  int         rlvl = 0;
  logic [7:0] rhold = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_main(input string tag);
    chk({tag, ".lvl"},  32'(level),        32'(mlvl));
    chk({tag, ".full"}, 32'(full),         32'(mlvl == 42));
    chk({tag, ".emp"},  32'(empty),        32'(mlvl == 0));
    chk({tag, ".af"},   32'(almost_full),  32'(mlvl >= 40));
    chk({tag, ".ae"},   32'(almost_empty), 32'(mlvl <= 2));
    chk({tag, ".ovf"},  32'(overflow),     32'(movf));
    chk({tag, ".unf"},  32'(underflow),    32'(munf));
    chk({tag, ".dout"}, 32'(data_out),     (mlvl > 0) ? 32'(q[0]) : 32'h0);
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic op(input bit wr, input logic [7:0] d, input bit rd, input bit clr, input string tag);
    bit wacc, racc;
    logic [7:0] exp;
    wr_en = wr; rd_en = rd; data_in = d; clr_err = clr;
    racc = rd && (mlvl > 0);
    wacc = wr && ((mlvl < 42) || racc);
    #1;
    if (racc) begin
      exp = q.pop_front();
      chk({tag, ".rd"}, 32'(data_out), 32'(exp));
    end
    if (clr) begin movf = 0; munf = 0; end
    if (wr && !wacc) movf = 1;
    if (rd && !racc) munf = 1;
    if (wacc) q.push_back(d);
    mlvl = mlvl + int'(wacc) - int'(racc);
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; clr_err = 0;
    chk_main(tag);
  endtask

  task automatic r_op(input bit wr, input logic [7:0] d, input bit rd, input string tag);
    bit racc, wacc;
    r_wr_en = wr; r_rd_en = rd; r_data_in = d;
    racc = rd && (rlvl > 0);
    wacc = wr && ((rlvl < 5) || racc);
    if (racc) rhold = rq.pop_front();
    if (wacc) rq.push_back(d);
    rlvl = rlvl + int'(wacc) - int'(racc);
    @(posedge clk); #1;
    r_wr_en = 0; r_rd_en = 0;
    chk({tag, ".dout"}, 32'(r_data_out), 32'(rhold));
    chk({tag, ".lvl"},  32'(r_level),    32'(rlvl));
    chk({tag, ".full"}, 32'(r_full),     32'(rlvl == 5));
    chk({tag, ".emp"},  32'(r_empty),    32'(rlvl == 0));
  endtask

  initial begin
    #2;
    chk_main("rst0");
    chk("rst0.r_dout", 32'(r_data_out), 32'h0);
    chk("rst0.r_emp",  32'(r_empty),    32'h1);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Fill, overflow, drain
    for (int i = 0; i < 42; i++) op(1, 8'(i), 0, 0, "fill");
    op(1, 8'hEE, 0, 0, "ovf");
    op(0, 8'h00, 0, 1, "clr1");
    for (int i = 0; i < 42; i++) op(0, 8'h00, 1, 0, "drain");

    // Pointer wrap past DEPTH
    for (int i = 0; i < 30; i++) op(1, 8'(8'h40 + i), 0, 0, "w1");
    for (int i = 0; i < 30; i++) op(0, 8'h00, 1, 0, "r1");
    for (int i = 0; i < 30; i++) op(1, 8'(8'h80 + i), 0, 0, "w2");
    for (int i = 0; i < 30; i++) op(0, 8'h00, 1, 0, "r2");

    // Full with simultaneous write and read
    for (int i = 0; i < 42; i++) op(1, 8'(8'h60 + i), 0, 0, "fill2");
    op(1, 8'h55, 1, 0, "fullwr");
    for (int i = 0; i < 42; i++) op(0, 8'h00, 1, 0, "drain2");

    // Empty with simultaneous write and read
    op(1, 8'hA5, 1, 0, "empwr");
    chk("empwr.a5", 32'(data_out), 32'hA5);
    op(0, 8'h00, 0, 1, "clr2");
    op(0, 8'h00, 1, 0, "rdA5");
    op(0, 8'h00, 1, 0, "unf2");

    // Flush at level 17 with a write pending; underflow must survive
    for (int i = 0; i < 17; i++) op(1, 8'(8'hC0 + i), 0, 0, "w17");
    flush = 1; wr_en = 1; data_in = 8'hFF;
    @(posedge clk); #1;
    flush = 0; wr_en = 0;
    mlvl = 0; q.delete();
    chk_main("flush");

    // Asynchronous reset in the middle of a write burst
    for (int i = 0; i < 3; i++) op(1, 8'(8'hD0 + i), 0, 0, "burst");
    wr_en = 1; data_in = 8'hD3;
    #2;
    rst = 1;
    #1;
    mlvl = 0; q.delete(); movf = 0; munf = 0;
    chk_main("arst");
    @(posedge clk); #1;
    wr_en = 0;
    chk_main("arst_hold");
    rst = 0;
    op(1, 8'h3C, 0, 0, "resume");
    op(0, 8'h00, 1, 0, "resume_rd");

    // Registered-output instance
    for (int i = 0; i < 5; i++) r_op(1, 8'(8'h11 + i), 0, "r_w");
    r_op(1, 8'h99, 0, "r_ovf");
    chk("r_ovf.flag", 32'(r_ovf), 32'h1);
    for (int i = 0; i < 5; i++) begin
      r_op(0, 8'h00, 1, "r_rd");
      r_op(0, 8'h00, 0, "r_hold");
    end
    chk("r_unf.flag", 32'(r_unf), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end

endmodule

// File: doc/syn_fifo_gen.md
# syn_fifo_gen

Parametrised single-clock FIFO, successor to the fixed 42-entry TX/RX buffer in the TXRX submodule. Adds true DEPTH-entry capacity with any non-power-of-two depth, guarded writes and reads, programmable almost-full and almost-empty thresholds, an occupancy output, sticky overflow and underflow flags, and a selectable output mode: first-word-fall-through or registered. It sits between the TXRX byte engines and the CPU-side register interface.

## Interface
- DATA_WIDTH, 8, word width
- ADDR_WIDTH, 6, pointer width; DEPTH ≤ 2^ADDR_WIDTH
- DEPTH, 42, usable entries (2..2^ADDR_WIDTH)
- AFULL_THR, DEPTH-2, almost_full asserts when level ≥ AFULL_THR
- AEMPTY_THR, 2, almost_empty asserts when level ≤ AEMPTY_THR
- FWFT, 1, 1 = head word shown combinationally; 0 = registered read data
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of contents
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- data_out  out  DATA_WIDTH  read data
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- almost_empty  out  1  level ≤ AEMPTY_THR
- almost_full  out  1  level ≥ AFULL_THR
- level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected
- clr_err  in  1  synchronous clear of overflow and underflow

## Operation
- Write accepted: wr_acc = wr_en & (~full | rd_acc). Read accepted: rd_acc = rd_en & ~empty.
- wr_ptr and rd_ptr advance on an accepted write or read. Each wraps from DEPTH-1 to 0, not at 2^ADDR_WIDTH.
- level is updated as follows:
  - +1 on wr_acc & ~rd_acc
  - -1 on rd_acc & ~wr_acc
  - unchanged otherwise
- Flags are derived only from the registered level, so they are glitch-free relative to clk.
- A rejected write (wr_en & ~wr_acc) sets overflow. A rejected read (rd_en & empty) sets underflow.
  - Both flags hold until rst or clr_err.
  - clr_err and a same-cycle rejection: the set wins.
- Priority: rst > flush > normal operation.
  - flush zeroes wr_ptr, rd_ptr and level; registered data_out goes to 0.
  - flush does not clear the error flags.
  - wr_en and rd_en are ignored in a flush cycle; they set no error flags.
- FWFT=1: data_out = mem[rd_ptr] when ~empty, else 0.
- FWFT=0: data_out loads mem[rd_ptr] on rd_acc, otherwise holds.
- Storage contents are not reset.

## Timing
- Reset values: empty=1, full=0, almost_empty=1, almost_full=0 (given AFULL_THR ≥ 1), level=0, overflow=0, underflow=0, data_out=0.
- Write latency: a word written at edge N is counted in level after N. In FWFT mode it appears on data_out after N if the FIFO was empty.
- Read latency:
  - FWFT=1: data valid in the same cycle rd_en is sampled.
  - FWFT=0: data valid one cycle after the accepted read edge.
- Simultaneous wr+rd when full: both accepted, level stays DEPTH, no overflow.
- Simultaneous wr+rd when empty: write accepted, read rejected, underflow set, level becomes 1.
- rst asserted mid-burst: all outputs go to reset values immediately (asynchronous). Operation resumes on the first edge after deassertion.

## Structure
- Shared package: an ADDR_WIDTH-derived level width constant, and the FWFT mode encoding constants.
- One sub-module, fifo_regf_2p:
  - DEPTH×DATA_WIDTH register file.
  - One synchronous write port and one asynchronous read port.
  - The parent provides the registered output stage for FWFT=0.
- Controller logic covers pointers, level, flags and error flags in the top.

## Test plan
- Defaults, reset then 42 writes of 0x00..0x29:
  - full=1 after the 42nd write; almost_full=1 from level 40.
  - A 43rd write sets overflow with level=42.
  - 42 reads return 0x00..0x29 in order.
- Wrap: 30 writes, 30 reads, 30 writes of 0x80..0x9D, 30 reads → data 0x80..0x9D. Pointers wrap at 42; level ends at 0.
- Full with simultaneous wr+rd of 0x55: data_out sequence is unchanged, level stays 42, overflow=0.
- Empty with rd_en=1 and wr_en=1 (0xA5): underflow=1, level=1.
  - FWFT=1: next cycle data_out=0xA5.
  - clr_err then clears underflow.
- flush at level 17 with wr_en=1: level=0, empty=1 next cycle, no error flags change.
  - Then rst pulsed mid-write of a second burst: every output returns to its reset value asynchronously.
- FWFT=0, DEPTH=5, ADDR_WIDTH=3: write 0x11..0x15, then read. data_out shows 0x11 one cycle after the first read edge and holds between reads.
